mem_access_sequencer: RTL
=========================

Name: mem_access_sequencer

Overview:
- Data-memory access controller in the MEM stage; sits between the pipeline load/store request and the single-port data memory.
- Sequences every load/store into one or two word-aligned memory transactions on a req/ack handshake.
- Splits accesses that cross a word boundary and generates byte write-enables.
- Merges, aligns and sign/zero-extends read data, and stalls the pipeline via req_ready while busy.

Parameters:
- SPLIT_EN, 1: 1 = split boundary-crossing accesses into two transactions; 0 = flag them on misalign_err and perform no memory access.

Ports:
- clk  in  1  clock; sole clock domain
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  pipeline presents a load/store
- req_ready  out  1  sequencer can accept a request (pipeline stalls while 0)
- mem_op  in  5  [1:0] size (00 byte, 01 half, 10 word, 11 reserved); [2] 0 signed / 1 unsigned; [3] 1 store / 0 load; [4] access enable
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle pulse: request complete
- rdata  out  32  aligned, extended load data; valid with rsp_valid
- misalign_err  out  1  one-cycle pulse, replaces rsp_valid for a rejected access
- dm_req  out  1  memory transaction request
- dm_addr  out  32  word address (bits [1:0] = 00)
- dm_we  out  4  byte write-enables; 0000 = read
- dm_wdata  out  32  store data rotated to byte lanes
- dm_ack  in  1  memory completes the current transaction this cycle
- dm_rdata  in  32  read word; valid when dm_ack=1

Behaviour:
- States: IDLE, ACC0, ACC1, DONE.
- Reset (rst=1 at a clk edge): state IDLE. req_ready=1; rsp_valid, misalign_err, dm_req=0; dm_we=0000; rdata, dm_addr, dm_wdata=0.
- Reset mid-transaction abandons it; dm_req is 0 from the cycle after the reset edge.
- Outputs are decoded from registered state only, with no combinational path from req_valid to dm_req.
- IDLE: req_ready=1. Accept when req_valid=1 and mem_op[4]=1; latch mem_op, addr, wdata; go to ACC0.
  - req_valid with mem_op[4]=0 is ignored.
  - Reserved size 11 completes immediately: DONE with rdata=0 and no memory access.
- Geometry: off = addr[1:0]; nbytes = 1/2/4. cross = (off + nbytes > 4).
- If cross and SPLIT_EN=0: go to DONE with misalign_err=1, rsp_valid=0, no dm_req.
- Byte mask: m = 0001 / 0011 / 1111.
  - ACC0: dm_addr = {addr[31:2], 00}; byte enables = (m << off)[3:0].
  - ACC1: dm_addr = ACC0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000); byte enables = m >> (4 - off).
- dm_we = byte enables for stores, 0000 for loads.
- dm_wdata = wdata rotated left by 8*off; identical in both transactions.
- ACC0/ACC1: dm_req=1 and dm_addr/dm_we/dm_wdata stable until the dm_ack cycle.
  - dm_ack in ACC0: go to ACC1 if cross, else DONE.
  - dm_ack in ACC1: go to DONE.
  - Wait states are unbounded.
- Load merge: capture dm_rdata at each ack. assembled = (w0 >> 8*off) | (w1 << 8*(4 - off)); w1 term is 0 when not cross.
  - Byte: extend assembled[7:0]. Half: extend assembled[15:0]. Sign extension when mem_op[2]=0, zero extension when mem_op[2]=1. Word: assembled.
- Stores return rdata=0.
- DONE: exactly one cycle. rsp_valid=1 (or misalign_err=1); req_ready=0; then IDLE.
- Latency with zero-wait memory: accept edge T; ACC0 in cycle T+1 with ack; DONE in T+2 (3 cycles request to response). A split access adds 1 cycle plus wait states.
- A new request is accepted no earlier than the cycle after DONE.

Test Plan:
- Aligned signed byte load: addr=0x1002, mem_op=5'b10000, dm_rdata=0x12845678 -> one transaction, dm_addr=0x1000, dm_we=0000, rdata=0xFFFFFF84, rsp_valid 3 cycles after accept.
- Aligned store half: addr=0x2002, wdata=0x0000BEEF, mem_op=5'b11001 -> dm_we=1100, dm_wdata=0xBEEF0000, single transaction, rsp_valid with rdata=0.
- Split unsigned word load: addr=0x3003, dm_rdata 0xAABBCCDD then 0x11223344 -> dm_addr 0x3000 then 0x3004, rdata=0x223344AA.
- Split store word with 2 wait cycles on each ack: addr=0x4001, wdata=0x11223344 -> dm_we 1110 then 0001, dm_wdata=0x22334411 held through waits, req_ready=0 until after DONE.
- SPLIT_EN=0 and addr=0x5003 half load -> misalign_err pulse, no dm_req, rsp_valid=0; address wrap with SPLIT_EN=1, addr=0xFFFFFFFE word -> second dm_addr=0x00000000.
- rst asserted while in ACC1 waiting on dm_ack -> next cycle IDLE, dm_req=0, req_ready=1, no rsp_valid ever issued for the aborted request.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// MEM-stage load/store sequencer: one or two word transactions per access on a req/ack memory port.
// Three cycles request-to-response with a zero-wait memory, plus one for a split access; req_ready is low while busy.
`timescale 1ns/1ps
module mem_access_sequencer #(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic        uns_q, uns_d, store_q, store_d, cross_q, cross_d;
  logic [31:0] w0_q, w0_d;
  logic        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic        misalign_err_q, misalign_err_d, dm_req_q, dm_req_d;
  logic [31:0] rdata_q, rdata_d, dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_we_q, dm_we_d;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                         input logic uns);
    logic [31:0] r;
    case (size)
      2'b00:   r = {{24{v[7] & ~uns}}, v[7:0]};
      2'b01:   r = {{16{v[15] & ~uns}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  logic [1:0]  in_off;
  logic        in_cross;
  logic [5:0]  in_sh, q_sh;
  logic [31:0] in_rot, asm_single, asm_split;
  logic [3:0]  in_be0, be1;

  always_comb begin
    in_off     = addr[1:0];
    in_cross   = ({1'b0, in_off} + size_bytes(mem_op[1:0])) > 3'd4;
    in_sh      = {1'b0, in_off, 3'b000};
    in_rot     = (wdata << in_sh) | (wdata >> (6'd32 - in_sh));
    in_be0     = size_mask(mem_op[1:0]) << in_off;
    q_sh       = {1'b0, off_q, 3'b000};
    be1        = size_mask(size_q) >> (3'd4 - {1'b0, off_q});
    asm_single = dm_rdata >> q_sh;
    // Second word supplies the upper bytes of a boundary-crossing load.
    asm_split  = (w0_q >> q_sh) | (dm_rdata << (6'd32 - q_sh));
  end

  logic        fin;
  logic [31:0] fin_asm;

  always_comb begin
    state_d        = state_q;
    size_d         = size_q;
    off_d          = off_q;
    uns_d          = uns_q;
    store_d        = store_q;
    cross_d        = cross_q;
    w0_d           = w0_q;
    rdata_d        = rdata_q;
    dm_req_d       = dm_req_q;
    dm_addr_d      = dm_addr_q;
    dm_we_d        = dm_we_q;
    dm_wdata_d     = dm_wdata_q;
    rsp_valid_d    = 1'b0;
    misalign_err_d = 1'b0;
    fin            = 1'b0;
    fin_asm        = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && mem_op[4]) begin
          size_d  = mem_op[1:0];
          uns_d   = mem_op[2];
          store_d = mem_op[3];
          off_d   = in_off;
          cross_d = in_cross;
          if (mem_op[1:0] == 2'b11) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
          end else if (in_cross && !SPLIT_EN) begin
            state_d        = DONE;
            misalign_err_d = 1'b1;
          end else begin
            state_d    = ACC0;
            dm_req_d   = 1'b1;
            dm_addr_d  = {addr[31:2], 2'b00};
            dm_we_d    = mem_op[3] ? in_be0 : 4'b0000;
            dm_wdata_d = in_rot;
          end
        end
      end
      ACC0: begin
        if (dm_ack) begin
          w0_d = dm_rdata;
          if (cross_q) begin
            state_d   = ACC1;
            dm_addr_d = dm_addr_q + 32'd4;
            dm_we_d   = store_q ? be1 : 4'b0000;
          end else begin
            fin     = 1'b1;
            fin_asm = asm_single;
          end
        end
      end
      ACC1: begin
        if (dm_ack) begin
          fin     = 1'b1;
          fin_asm = asm_split;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d     = DONE;
      dm_req_d    = 1'b0;
      dm_addr_d   = '0;
      dm_we_d     = 4'b0000;
      dm_wdata_d  = '0;
      rsp_valid_d = 1'b1;
      rdata_d     = store_q ? '0 : extend(fin_asm, size_q, uns_q);
    end
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      size_q         <= 2'b00;
      off_q          <= 2'b00;
      uns_q          <= 1'b0;
      store_q        <= 1'b0;
      cross_q        <= 1'b0;
      w0_q           <= '0;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      misalign_err_q <= 1'b0;
      rdata_q        <= '0;
      dm_req_q       <= 1'b0;
      dm_addr_q      <= '0;
      dm_we_q        <= 4'b0000;
      dm_wdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      size_q         <= size_d;
      off_q          <= off_d;
      uns_q          <= uns_d;
      store_q        <= store_d;
      cross_q        <= cross_d;
      w0_q           <= w0_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      misalign_err_q <= misalign_err_d;
      rdata_q        <= rdata_d;
      dm_req_q       <= dm_req_d;
      dm_addr_q      <= dm_addr_d;
      dm_we_q        <= dm_we_d;
      dm_wdata_q     <= dm_wdata_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign misalign_err = misalign_err_q;
  assign rdata        = rdata_q;
  assign dm_req       = dm_req_q;
  assign dm_addr      = dm_addr_q;
  assign dm_we        = dm_we_q;
  assign dm_wdata     = dm_wdata_q;

endmodule
